// File: rtl/axi_sram_responder.sv
// rtl/axi_sram_responder.sv - AXI4 responder backed by an internal SRAM array with independent read/write FSMs.
// Optional feature macro: AXI_SRAM_WRAP_EN (enables WRAP bursts; otherwise WRAP bursts answer SLVERR).
module axi_sram_responder #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int MEM_WORDS  = 4096
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LOG2B  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
`ifdef AXI_SRAM_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic [7:0] len,
                                                      input logic [2:0] size,
                                                      input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] sum;
    logic [ADDR_WIDTH-1:0] mask;
    sum  = addr + (ADDR_WIDTH'(1) << size);
    mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    if (burst == BURST_FIXED) return addr;
    else if (WRAP_EN && burst == BURST_WRAP) return (addr & ~mask) | (sum & mask);
    else return sum;
  endfunction

  // Whole-burst errors decided at the address handshake; per-beat range errors come later.
  function automatic logic burst_err(input logic [ADDR_WIDTH-1:0] addr,
                                     input logic [7:0] len,
                                     input logic [2:0] size,
                                     input logic [1:0] burst);
    logic wrap_bad;
    wrap_bad = !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15) ||
               ((addr & ((ADDR_WIDTH'(1) << size) - ADDR_WIDTH'(1))) != '0);
    return (size > 3'(LOG2B)) || (burst == BURST_RSVD) ||
           ((burst == BURST_WRAP) && (!WRAP_EN || wrap_bad));
  endfunction

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return (addr >> LOG2B) < ADDR_WIDTH'(MEM_WORDS);
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic                  init_q;
  w_state_e              w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   aw_id_q, aw_id_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [7:0]            aw_len_q, aw_len_d, w_cnt_q, w_cnt_d;
  logic [2:0]            aw_size_q, aw_size_d;
  logic [1:0]            aw_burst_q, aw_burst_d;
  logic                  w_err_q, w_err_d, w_berr_q, w_berr_d;
  logic                  mem_we, w_at_last, w_in_range;

  r_state_e              r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   ar_id_q, ar_id_d;
  logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
  logic [7:0]            ar_len_q, ar_len_d, r_cnt_q, r_cnt_d;
  logic [2:0]            ar_size_q, ar_size_d;
  logic [1:0]            ar_burst_q, ar_burst_d;
  logic                  r_berr_q, r_berr_d, r_legal;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rlast_q, rlast_d;

  assign w_at_last  = (w_cnt_q == aw_len_q);
  assign w_in_range = in_range(aw_addr_q);
  assign r_legal    = !r_berr_q && in_range(ar_addr_q);

  always_comb begin
    w_state_d  = w_state_q;
    aw_id_d    = aw_id_q;
    aw_addr_d  = aw_addr_q;
    aw_len_d   = aw_len_q;
    aw_size_d  = aw_size_q;
    aw_burst_d = aw_burst_q;
    w_cnt_d    = w_cnt_q;
    w_err_d    = w_err_q;
    w_berr_d   = w_berr_q;
    mem_we     = 1'b0;
    awready    = init_q && (w_state_q == W_IDLE);
    wready     = (w_state_q == W_DATA);
    bvalid     = (w_state_q == W_RESP);
    bresp      = (bvalid && w_err_q) ? RESP_SLVERR : RESP_OKAY;
    bid        = aw_id_q;
    case (w_state_q)
      W_IDLE: if (awvalid && awready) begin
        aw_id_d    = awid;
        aw_addr_d  = awaddr;
        aw_len_d   = awlen;
        aw_size_d  = awsize;
        aw_burst_d = awburst;
        w_cnt_d    = '0;
        w_berr_d   = burst_err(awaddr, awlen, awsize, awburst);
        w_err_d    = w_berr_d;
        w_state_d  = W_DATA;
      end
      W_DATA: if (wvalid) begin
        mem_we = !w_berr_q && w_in_range;
        if (!w_in_range || (wlast != w_at_last)) w_err_d = 1'b1;
        if (wlast || w_at_last) begin
          w_state_d = W_RESP;
        end else begin
          w_cnt_d   = w_cnt_q + 8'd1;
          aw_addr_d = next_addr(aw_addr_q, aw_len_q, aw_size_q, aw_burst_q);
        end
      end
      W_RESP: if (bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d  = r_state_q;
    ar_id_d    = ar_id_q;
    ar_addr_d  = ar_addr_q;
    ar_len_d   = ar_len_q;
    ar_size_d  = ar_size_q;
    ar_burst_d = ar_burst_q;
    r_cnt_d    = r_cnt_q;
    r_berr_d   = r_berr_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rlast_d    = rlast_q;
    arready    = init_q && (r_state_q == R_IDLE);
    rvalid     = (r_state_q == R_DATA);
    rid        = ar_id_q;
    rdata      = rdata_q;
    rresp      = rresp_q;
    rlast      = rlast_q;
    case (r_state_q)
      R_IDLE: if (arvalid && arready) begin
        ar_id_d    = arid;
        ar_addr_d  = araddr;
        ar_len_d   = arlen;
        ar_size_d  = arsize;
        ar_burst_d = arburst;
        r_cnt_d    = '0;
        r_berr_d   = burst_err(araddr, arlen, arsize, arburst);
        r_state_d  = R_FETCH;
      end
      R_FETCH: begin
        // Registered read of the old word: a same-cycle write lands after this sample.
        rdata_d   = r_legal ? mem[ar_addr_q[LOG2B +: IDX_W]] : '0;
        rresp_d   = r_legal ? RESP_OKAY : RESP_SLVERR;
        rlast_d   = (r_cnt_q == ar_len_q);
        r_state_d = R_DATA;
      end
      R_DATA: if (rready) begin
        if (rlast_q) begin
          r_state_d = R_IDLE;
        end else begin
          r_cnt_d   = r_cnt_q + 8'd1;
          ar_addr_d = next_addr(ar_addr_q, ar_len_q, ar_size_q, ar_burst_q);
          r_state_d = R_FETCH;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      init_q     <= 1'b0;
      w_state_q  <= W_IDLE;
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      w_cnt_q    <= '0;
      w_err_q    <= 1'b0;
      w_berr_q   <= 1'b0;
      r_state_q  <= R_IDLE;
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      r_cnt_q    <= '0;
      r_berr_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= '0;
      rlast_q    <= 1'b0;
    end else begin
      init_q     <= 1'b1;
      w_state_q  <= w_state_d;
      aw_id_q    <= aw_id_d;
      aw_addr_q  <= aw_addr_d;
      aw_len_q   <= aw_len_d;
      aw_size_q  <= aw_size_d;
      aw_burst_q <= aw_burst_d;
      w_cnt_q    <= w_cnt_d;
      w_err_q    <= w_err_d;
      w_berr_q   <= w_berr_d;
      r_state_q  <= r_state_d;
      ar_id_q    <= ar_id_d;
      ar_addr_q  <= ar_addr_d;
      ar_len_q   <= ar_len_d;
      ar_size_q  <= ar_size_d;
      ar_burst_q <= ar_burst_d;
      r_cnt_q    <= r_cnt_d;
      r_berr_q   <= r_berr_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rlast_q    <= rlast_d;
    end
  end

  // SRAM contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[aw_addr_q[LOG2B +: IDX_W]][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_responder.sv
// tb/tb_axi_sram_responder.sv - Directed self-checking bench for axi_sram_responder.
module tb_axi_sram_responder;
  localparam int MW = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic [3:0]  awid, arid, bid, rid;
  logic [63:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  axi_sram_responder #(.ID_WIDTH(4), .ADDR_WIDTH(64), .DATA_WIDTH(64), .MEM_WORDS(MW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  int checks = 0;
  int failures = 0;
  logic [63:0] wbuf [16];
  logic [63:0] rb_data [16];
  logic [1:0]  rb_resp [16];
  logic        rb_last [16];
  logic [3:0]  rb_id [16];
  logic [1:0]  b_resp;
  logic [3:0]  b_id;
  bit          ok;

  task automatic do_aw(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst, output bit okay);
    @(negedge clk);
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    okay = 1'b0;
    for (int t = 0; t < 50; t++) begin
      if (awready) begin okay = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic do_ar(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst, output bit okay);
    @(negedge clk);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    okay = 1'b0;
    for (int t = 0; t < 50; t++) begin
      if (arready) begin okay = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  task automatic do_w(input int n, input int last_at, input logic [7:0] strb, output bit okay);
    bit got;
    okay = 1'b1;
    for (int i = 0; i < n; i++) begin
      wvalid = 1'b1; wdata = wbuf[i]; wstrb = strb; wlast = (i == last_at);
      got = 1'b0;
      for (int t = 0; t < 50; t++) begin
        if (wready) begin got = 1'b1; break; end
        @(negedge clk);
      end
      if (!got) okay = 1'b0;
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic do_b(output logic [1:0] resp, output logic [3:0] id, output bit okay);
    resp = 2'bxx; id = 4'bxxxx; okay = 1'b0;
    bready = 1'b1;
    for (int t = 0; t < 50; t++) begin
      if (bvalid) begin okay = 1'b1; resp = bresp; id = bid; break; end
      @(negedge clk);
    end
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic do_r(input int n, output bit okay);
    bit got;
    okay = 1'b1;
    rready = 1'b1;
    for (int i = 0; i < n; i++) begin
      got = 1'b0;
      rb_data[i] = 'x; rb_resp[i] = 'x; rb_last[i] = 1'bx; rb_id[i] = 'x;
      for (int t = 0; t < 50; t++) begin
        if (rvalid) begin
          got = 1'b1; rb_data[i] = rdata; rb_resp[i] = rresp; rb_last[i] = rlast; rb_id[i] = rid;
          break;
        end
        @(negedge clk);
      end
      if (!got) okay = 1'b0;
      @(negedge clk);
    end
    rready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({awready, arready, wready, bvalid, bresp, bid, rvalid, rdata, rresp, rlast, rid} !== '0) begin
      failures++; $display("FAIL reset_held_outputs: got nonzero outputs awready=%b arready=%b rvalid=%b rdata=%h expected all 0", awready, arready, rvalid, rdata);
    end
    rst_n = 1'b1;
    checks++;
    if (awready !== 1'b0) begin failures++; $display("FAIL reset_release_awready: got %b expected 0", awready); end
    @(negedge clk);
    checks++;
    if (awready !== 1'b1) begin failures++; $display("FAIL reset_awready: got %b expected 1", awready); end
    checks++;
    if (arready !== 1'b1) begin failures++; $display("FAIL reset_arready: got %b expected 1", arready); end
    checks++;
    if ({wready, bvalid, bresp, bid, rvalid, rdata, rresp, rlast, rid} !== '0) begin
      failures++; $display("FAIL reset_other_outputs: got wready=%b bvalid=%b rvalid=%b rdata=%h expected all 0", wready, bvalid, rvalid, rdata);
    end
  endtask

  task automatic test_incr();
    logic [63:0] exp_d;
    for (int i = 0; i < 4; i++) wbuf[i] = 64'hA0 + 64'(i);
    do_aw(4'd5, 64'h100, 8'd3, 3'd3, 2'b01, ok);
    checks++; if (!ok) begin failures++; $display("FAIL incr_aw_timeout: got no awready expected handshake"); end
    do_w(4, 3, 8'hFF, ok);
    checks++; if (!ok) begin failures++; $display("FAIL incr_w_timeout: got no wready expected 4 beats"); end
    do_b(b_resp, b_id, ok);
    checks++; if (!ok || b_resp !== 2'b00) begin failures++; $display("FAIL incr_bresp: got %b expected 00", b_resp); end
    checks++; if (b_id !== 4'd5) begin failures++; $display("FAIL incr_bid: got %h expected 5", b_id); end
    checks++; if (bvalid !== 1'b0) begin failures++; $display("FAIL incr_single_bvalid: got %b expected 0", bvalid); end
    do_ar(4'd6, 64'h100, 8'd3, 3'd3, 2'b01, ok);
    checks++; if (!ok || rvalid !== 1'b0) begin failures++; $display("FAIL incr_latency_n1: got rvalid=%b expected 0", rvalid); end
    @(negedge clk);
    checks++; if (rvalid !== 1'b1) begin failures++; $display("FAIL incr_latency_n2: got rvalid=%b expected 1", rvalid); end
    do_r(4, ok);
    checks++; if (!ok) begin failures++; $display("FAIL incr_r_timeout: got missing beats expected 4"); end
    for (int i = 0; i < 4; i++) begin
      exp_d = 64'hA0 + 64'(i);
      checks++;
      if (rb_data[i] !== exp_d || rb_resp[i] !== 2'b00 || rb_last[i] !== (i == 3) || rb_id[i] !== 4'd6) begin
        failures++;
        $display("FAIL incr_read_beat%0d: got data=%h resp=%b last=%b id=%h expected data=%h resp=00 last=%b id=6",
                 i, rb_data[i], rb_resp[i], rb_last[i], rb_id[i], exp_d, (i == 3));
      end
    end
  endtask

  task automatic test_partial_strobe();
    wbuf[0] = 64'h1111_2222_3333_4444;
    do_aw(4'd1, 64'h200, 8'd0, 3'd3, 2'b01, ok);
    do_w(1, 0, 8'hFF, ok);
    do_b(b_resp, b_id, ok);
    wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    do_aw(4'd1, 64'h200, 8'd0, 3'd3, 2'b01, ok);
    do_w(1, 0, 8'h0F, ok);
    do_b(b_resp, b_id, ok);
    checks++; if (!ok || b_resp !== 2'b00) begin failures++; $display("FAIL strobe_bresp: got %b expected 00", b_resp); end
    do_ar(4'd2, 64'h200, 8'd0, 3'd3, 2'b01, ok);
    do_r(1, ok);
    checks++;
    if (rb_data[0] !== 64'h1111_2222_FFFF_FFFF) begin
      failures++; $display("FAIL strobe_readback: got %h expected 1111_2222_ffff_ffff", rb_data[0]);
    end
  endtask

  task automatic test_backpressure();
    bit got;
    do_ar(4'd3, 64'h100, 8'd3, 3'd3, 2'b01, ok);
    do_r(1, ok);
    got = 1'b0;
    for (int t = 0; t < 50; t++) begin
      if (rvalid) begin got = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!got) begin failures++; $display("FAIL bp_beat2_timeout: got no rvalid expected beat 2"); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (rvalid !== 1'b1 || rdata !== 64'hA1 || rlast !== 1'b0) begin
        failures++; $display("FAIL bp_hold_cycle%0d: got rvalid=%b rdata=%h rlast=%b expected 1 a1 0", k, rvalid, rdata, rlast);
      end
    end
    do_r(3, ok);
    checks++;
    if (rb_data[0] !== 64'hA1 || rb_data[1] !== 64'hA2 || rb_data[2] !== 64'hA3 || rb_last[2] !== 1'b1) begin
      failures++; $display("FAIL bp_tail: got %h %h %h last=%b expected a1 a2 a3 last=1", rb_data[0], rb_data[1], rb_data[2], rb_last[2]);
    end
    wbuf[0] = 64'h55;
    do_aw(4'd4, 64'h300, 8'd0, 3'd3, 2'b01, ok);
    do_w(1, 0, 8'hFF, ok);
    got = 1'b0;
    for (int t = 0; t < 50; t++) begin
      if (bvalid) begin got = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!got) begin failures++; $display("FAIL bp_bvalid_timeout: got no bvalid expected 1"); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (bvalid !== 1'b1 || awready !== 1'b0) begin
        failures++; $display("FAIL bp_bhold_cycle%0d: got bvalid=%b awready=%b expected 1 0", k, bvalid, awready);
      end
    end
    do_b(b_resp, b_id, ok);
    checks++; if (b_resp !== 2'b00 || b_id !== 4'd4) begin failures++; $display("FAIL bp_bresp: got %b id %h expected 00 id 4", b_resp, b_id); end
  endtask

  task automatic test_errors();
    do_ar(4'd7, 64'(MW * 8), 8'd1, 3'd3, 2'b01, ok);
    do_r(2, ok);
    checks++;
    if (!ok || rb_resp[0] !== 2'b10 || rb_resp[1] !== 2'b10 || rb_data[0] !== '0 || rb_data[1] !== '0 ||
        rb_last[0] !== 1'b0 || rb_last[1] !== 1'b1) begin
      failures++; $display("FAIL err_range_read: got resp %b %b data %h %h last %b %b expected 10 10 0 0 0 1",
                           rb_resp[0], rb_resp[1], rb_data[0], rb_data[1], rb_last[0], rb_last[1]);
    end
    wbuf[0] = 64'hDEAD;
    do_aw(4'd8, 64'h100, 8'd0, 3'd4, 2'b01, ok);
    do_w(1, 0, 8'hFF, ok);
    do_b(b_resp, b_id, ok);
    checks++; if (b_resp !== 2'b10) begin failures++; $display("FAIL err_size_bresp: got %b expected 10", b_resp); end
    do_ar(4'd8, 64'h100, 8'd0, 3'd3, 2'b01, ok);
    do_r(1, ok);
    checks++; if (rb_data[0] !== 64'hA0 || rb_resp[0] !== 2'b00) begin failures++; $display("FAIL err_size_unchanged: got %h resp %b expected a0 00", rb_data[0], rb_resp[0]); end
    wbuf[0] = 64'hB0; wbuf[1] = 64'hB1;
    do_aw(4'd9, 64'h180, 8'd3, 3'd3, 2'b01, ok);
    do_w(2, 1, 8'hFF, ok);
    do_b(b_resp, b_id, ok);
    checks++; if (!ok || b_resp !== 2'b10 || b_id !== 4'd9) begin failures++; $display("FAIL err_early_wlast: got %b id %h expected 10 id 9", b_resp, b_id); end
  endtask

  task automatic test_wrap();
    logic [63:0] exp_d [4];
    logic [1:0]  exp_r;
`ifdef AXI_SRAM_WRAP_EN
    exp_d[0] = 64'hA3; exp_d[1] = 64'hA0; exp_d[2] = 64'hA1; exp_d[3] = 64'hA2; exp_r = 2'b00;
`else
    for (int i = 0; i < 4; i++) exp_d[i] = '0;
    exp_r = 2'b10;
`endif
    do_ar(4'd10, 64'h118, 8'd3, 3'd3, 2'b10, ok);
    do_r(4, ok);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rb_data[i] !== exp_d[i] || rb_resp[i] !== exp_r || rb_last[i] !== (i == 3)) begin
        failures++; $display("FAIL wrap_beat%0d: got data=%h resp=%b last=%b expected data=%h resp=%b last=%b",
                             i, rb_data[i], rb_resp[i], rb_last[i], exp_d[i], exp_r, (i == 3));
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    bit got;
    wbuf[0] = 64'hC0;
    do_aw(4'd11, 64'h500, 8'd3, 3'd3, 2'b01, ok);
    do_w(1, -1, 8'hFF, ok);
    do_ar(4'd12, 64'h100, 8'd3, 3'd3, 2'b01, ok);
    do_r(1, ok);
    got = 1'b0;
    for (int t = 0; t < 50; t++) begin
      if (rvalid) begin got = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!got || wready !== 1'b1) begin failures++; $display("FAIL mid_setup: got rvalid=%b wready=%b expected 1 1", rvalid, wready); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({awready, arready, wready, bvalid, bresp, bid, rvalid, rdata, rresp, rlast, rid} !== '0) begin
      failures++; $display("FAIL mid_reset_outputs: got wready=%b rvalid=%b rdata=%h rid=%h expected all 0", wready, rvalid, rdata, rid);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wbuf[0] = 64'h77; wbuf[1] = 64'h88;
    do_aw(4'd13, 64'h400, 8'd1, 3'd3, 2'b01, ok);
    do_w(2, 1, 8'hFF, ok);
    do_b(b_resp, b_id, ok);
    checks++; if (!ok || b_resp !== 2'b00 || b_id !== 4'd13) begin failures++; $display("FAIL mid_new_write: got %b id %h expected 00 id d", b_resp, b_id); end
    do_ar(4'd14, 64'h400, 8'd1, 3'd3, 2'b01, ok);
    do_r(2, ok);
    checks++;
    if (!ok || rb_data[0] !== 64'h77 || rb_data[1] !== 64'h88 || rb_last[1] !== 1'b1 || rb_id[1] !== 4'd14) begin
      failures++; $display("FAIL mid_new_read: got %h %h last=%b id=%h expected 77 88 last=1 id=e", rb_data[0], rb_data[1], rb_last[1], rb_id[1]);
    end
    do_ar(4'd15, 64'h500, 8'd0, 3'd3, 2'b01, ok);
    do_r(1, ok);
    checks++; if (rb_data[0] !== 64'hC0) begin failures++; $display("FAIL mid_persist: got %h expected c0", rb_data[0]); end
  endtask

  initial begin
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    test_reset();
    test_incr();
    test_partial_strobe();
    test_backpressure();
    test_errors();
    test_wrap();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
